// File: rtl/easyaxi_rd_master.sv
// easyaxi_rd_master: issues NUM_BURSTS INCR read bursts, accumulates rdata and counts protocol/response errors
module easyaxi_rd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int BURST_LEN = 8,
  parameter int NUM_BURSTS = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h0000_1000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [ID_WIDTH-1:0]   arid,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [ID_WIDTH-1:0]   rid,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_cnt,
  output logic [DATA_WIDTH-1:0] data_sum
);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_IDX = 16'(NUM_BURSTS - 1);
  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] idx_q, idx_d, err_q, err_d;
  logic [7:0] beat_q, beat_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic last_beat;
  logic [1:0] err_inc;
  logic [16:0] err_sum;
  assign last_beat = beat_q == LAST_BEAT;
  assign err_inc = {1'b0, rresp != 2'b00} + {1'b0, rid != id_q} + {1'b0, rlast != last_beat};
  assign err_sum = {1'b0, err_q} + {15'd0, err_inc};
  assign arvalid = state_q == AR;
  assign rready = state_q == R;
  assign busy = arvalid | rready;
  assign done = state_q == DONE;
  assign araddr = addr_q;
  assign arid = id_q;
  assign arlen = LAST_BEAT;
  assign arsize = 3'($clog2(DATA_WIDTH / 8));
  assign arburst = 2'b01;
  assign err_cnt = err_q;
  assign data_sum = sum_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    beat_d = beat_q;
    err_d = err_q;
    sum_d = sum_q;
    addr_d = addr_q;
    id_d = id_q;
    case (state_q)
      IDLE: if (enable) begin
        state_d = AR;
        idx_d = '0;
        beat_d = '0;
        err_d = '0;
        sum_d = '0;
        addr_d = BASE_ADDR;
        id_d = '0;
      end
      AR: if (arready) begin
        state_d = R;
        beat_d = '0;
      end
      R: if (rvalid) begin
        sum_d = sum_q + rdata;
        err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        beat_d = beat_q + 8'd1;
        if (last_beat) begin
          state_d = idx_q < LAST_IDX ? AR : DONE;
          idx_d = idx_q < LAST_IDX ? idx_q + 16'd1 : idx_q;
          addr_d = idx_q < LAST_IDX ? addr_q + STRIDE : addr_q;
          id_d = idx_q < LAST_IDX ? id_q + ID_WIDTH'(1) : id_q;
        end
      end
      DONE: state_d = enable ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      beat_q <= '0;
      err_q <= '0;
      sum_q <= '0;
      addr_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      beat_q <= beat_d;
      err_q <= err_d;
      sum_q <= sum_d;
      addr_q <= addr_d;
      id_q <= id_d;
    end
  end
endmodule

// File: tb/tb_easyaxi_rd_master.sv
// tb_easyaxi_rd_master: directed checks of the read master against a scripted slave
module tb_easyaxi_rd_master;
  logic clk = 0, rst = 1, enable = 0, arready = 0, rvalid = 0, rlast = 0;
  logic [31:0] rdata = 0;
  logic [1:0] rresp = 0;
  logic [3:0] rid = 0;
  logic arvalid, rready, busy, done;
  logic [31:0] araddr, data_sum;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [3:0] arid;
  logic [15:0] err_cnt;
  int pass_cnt = 0, chk_cnt = 0, ar_hs = 0;
  easyaxi_rd_master #(.BURST_LEN(4), .NUM_BURSTS(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .busy(busy), .done(done), .err_cnt(err_cnt), .data_sum(data_sum)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (arvalid && arready) ar_hs <= ar_hs + 1;
  task automatic ar_phase(input logic [31:0] exp_addr, input logic [3:0] exp_id, input int stall);
    int n = 0;
    int h0;
    arready = 0;
    while (!arvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++; if (arvalid !== 1'b1) $display("FAIL ar_wait: arvalid=%b exp 1", arvalid); else pass_cnt++;
    chk_cnt++; if (araddr !== exp_addr) $display("FAIL araddr: got %h exp %h", araddr, exp_addr); else pass_cnt++;
    chk_cnt++; if (arid !== exp_id) $display("FAIL arid: got %h exp %h", arid, exp_id); else pass_cnt++;
    chk_cnt++; if ({arlen, arsize, arburst, busy} !== {8'd3, 3'd2, 2'b01, 1'b1})
      $display("FAIL ar_fields: len=%h size=%h burst=%b busy=%b exp 3/2/01/1", arlen, arsize, arburst, busy);
    else pass_cnt++;
    repeat (stall) begin
      @(negedge clk);
      chk_cnt++; if (arvalid !== 1'b1 || araddr !== exp_addr)
        $display("FAIL ar_stall: arvalid=%b araddr=%h exp 1/%h", arvalid, araddr, exp_addr);
      else pass_cnt++;
    end
    h0 = ar_hs;
    arready = 1;
    @(negedge clk);
    arready = 0;
    chk_cnt++; if (arvalid !== 1'b0 || rready !== 1'b1) $display("FAIL ar_to_r: arvalid=%b rready=%b exp 0/1", arvalid, rready); else pass_cnt++;
    chk_cnt++; if (ar_hs != h0 + 1) $display("FAIL ar_hs_count: got %0d exp %0d", ar_hs - h0, 1); else pass_cnt++;
  endtask
  task automatic r_phase(input logic [3:0][31:0] d, input logic [3:0][1:0] resp, input logic [3:0] lastm,
                         input logic [3:0] badid, input logic [3:0] id, input bit toggle);
    for (int b = 0; b < 4; b++) begin
      if (toggle && b > 0) begin
        rvalid = 0;
        rdata = 100;
        @(negedge clk);
      end
      chk_cnt++; if (rready !== 1'b1) $display("FAIL rready_beat%0d: got %b exp 1", b, rready); else pass_cnt++;
      rvalid = 1;
      rdata = d[b];
      rresp = resp[b];
      rlast = lastm[b];
      rid = id ^ {3'b0, badid[b]};
      @(negedge clk);
    end
    rvalid = 0;
    rresp = 0;
    rlast = 0;
    rid = 0;
  endtask
  task automatic junk_beat();
    rvalid = 1;
    rdata = 99;
    rresp = 2'b10;
    rlast = 1;
    rid = 5;
    @(negedge clk);
    rvalid = 0;
    rresp = 0;
    rlast = 0;
    rid = 0;
  endtask
  task automatic restart();
    enable = 0;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL idle_flags: done=%b busy=%b exp 0/0", done, busy); else pass_cnt++;
    enable = 1;
    @(negedge clk);
    chk_cnt++; if (data_sum !== 0 || err_cnt !== 0) $display("FAIL restart_clear: sum=%0d err=%0d exp 0/0", data_sum, err_cnt); else pass_cnt++;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    chk_cnt++; if ({arvalid, rready, busy, done} !== 4'b0) $display("FAIL reset_flags: got %b exp 0000", {arvalid, rready, busy, done}); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 0 || data_sum !== 0) $display("FAIL reset_counts: err=%0d sum=%0d exp 0/0", err_cnt, data_sum); else pass_cnt++;
    chk_cnt++; if (araddr !== 0 || arid !== 0) $display("FAIL reset_ar: araddr=%h arid=%h exp 0/0", araddr, arid); else pass_cnt++;
    rst = 0;
  endtask
  task automatic test_basic();
    enable = 1;
    @(negedge clk);
    ar_phase(32'h1000, 4'd0, 0);
    r_phase({32'd4, 32'd3, 32'd2, 32'd1}, '0, 4'b1000, 4'b0, 4'd0, 0);
    chk_cnt++; if (arvalid !== 1'b1) $display("FAIL gap: arvalid=%b exp 1", arvalid); else pass_cnt++;
    junk_beat();
    ar_phase(32'h1010, 4'd1, 0);
    r_phase({32'd8, 32'd7, 32'd6, 32'd5}, '0, 4'b1000, 4'b0, 4'd1, 0);
    chk_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_done: done=%b busy=%b exp 1/0", done, busy); else pass_cnt++;
    chk_cnt++; if (data_sum !== 36 || err_cnt !== 0) $display("FAIL basic_result: sum=%0d err=%0d exp 36/0", data_sum, err_cnt); else pass_cnt++;
    junk_beat();
    chk_cnt++; if (data_sum !== 36 || err_cnt !== 0 || done !== 1'b1)
      $display("FAIL done_hold: sum=%0d err=%0d done=%b exp 36/0/1", data_sum, err_cnt, done);
    else pass_cnt++;
    enable = 0;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b0 || data_sum !== 36) $display("FAIL idle_hold: done=%b sum=%0d exp 0/36", done, data_sum); else pass_cnt++;
  endtask
  task automatic test_ar_stall();
    int h0;
    restart();
    h0 = ar_hs;
    ar_phase(32'h1000, 4'd0, 5);
    r_phase({32'd40, 32'd30, 32'd20, 32'd10}, '0, 4'b1000, 4'b0, 4'd0, 0);
    ar_phase(32'h1010, 4'd1, 5);
    r_phase({32'd1, 32'd1, 32'd1, 32'd1}, '0, 4'b1000, 4'b0, 4'd1, 0);
    chk_cnt++; if (done !== 1'b1 || data_sum !== 104) $display("FAIL stall_result: done=%b sum=%0d exp 1/104", done, data_sum); else pass_cnt++;
    chk_cnt++; if (ar_hs - h0 != 2) $display("FAIL stall_hs: got %0d exp 2", ar_hs - h0); else pass_cnt++;
  endtask
  task automatic test_rvalid_toggle();
    restart();
    ar_phase(32'h1000, 4'd0, 0);
    r_phase({32'd4, 32'd3, 32'd2, 32'd1}, '0, 4'b1000, 4'b0, 4'd0, 1);
    ar_phase(32'h1010, 4'd1, 0);
    r_phase({32'd8, 32'd7, 32'd6, 32'd5}, '0, 4'b1000, 4'b0, 4'd1, 1);
    chk_cnt++; if (done !== 1'b1 || data_sum !== 36 || err_cnt !== 0)
      $display("FAIL toggle_result: done=%b sum=%0d err=%0d exp 1/36/0", done, data_sum, err_cnt);
    else pass_cnt++;
  endtask
  task automatic test_errors();
    restart();
    ar_phase(32'h1000, 4'd0, 0);
    r_phase({32'd1, 32'd1, 32'd1, 32'd1}, {2'b00, 2'b00, 2'b10, 2'b00}, 4'b1010, 4'b0, 4'd0, 0);
    chk_cnt++; if (err_cnt !== 2) $display("FAIL err_multi: got %0d exp 2", err_cnt); else pass_cnt++;
    chk_cnt++; if (arvalid !== 1'b1) $display("FAIL err_burst_end: arvalid=%b exp 1", arvalid); else pass_cnt++;
    ar_phase(32'h1010, 4'd1, 0);
    r_phase({32'd2, 32'd2, 32'd2, 32'd2}, '0, 4'b1000, 4'b0100, 4'd1, 0);
    chk_cnt++; if (done !== 1'b1 || err_cnt !== 3 || data_sum !== 12)
      $display("FAIL err_result: done=%b err=%0d sum=%0d exp 1/3/12", done, err_cnt, data_sum);
    else pass_cnt++;
  endtask
  task automatic test_enable_drop();
    restart();
    ar_phase(32'h1000, 4'd0, 0);
    enable = 0;
    r_phase({32'd4, 32'd3, 32'd2, 32'd1}, '0, 4'b1000, 4'b0, 4'd0, 0);
    ar_phase(32'h1010, 4'd1, 0);
    r_phase({32'd8, 32'd7, 32'd6, 32'd5}, '0, 4'b1000, 4'b0, 4'd1, 0);
    chk_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL drop_done: done=%b busy=%b exp 1/0", done, busy); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (done !== 1'b0 || arvalid !== 1'b0 || data_sum !== 36)
      $display("FAIL drop_idle: done=%b arvalid=%b sum=%0d exp 0/0/36", done, arvalid, data_sum);
    else pass_cnt++;
    enable = 1;
    @(negedge clk);
    chk_cnt++; if (arvalid !== 1'b1 || araddr !== 32'h1000 || data_sum !== 0 || err_cnt !== 0)
      $display("FAIL drop_restart: arvalid=%b araddr=%h sum=%0d err=%0d exp 1/1000/0/0", arvalid, araddr, data_sum, err_cnt);
    else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    ar_phase(32'h1000, 4'd0, 0);
    rvalid = 1;
    rdata = 50;
    repeat (2) @(negedge clk);
    chk_cnt++; if (data_sum !== 100 || rready !== 1'b1) $display("FAIL mid_partial: sum=%0d rready=%b exp 100/1", data_sum, rready); else pass_cnt++;
    rvalid = 0;
    rst = 1;
    @(negedge clk);
    chk_cnt++; if ({arvalid, rready, busy, done} !== 4'b0 || err_cnt !== 0 || data_sum !== 0 || araddr !== 0 || arid !== 0)
      $display("FAIL mid_reset: flags=%b err=%0d sum=%0d araddr=%h arid=%h exp all 0", {arvalid, rready, busy, done}, err_cnt, data_sum, araddr, arid);
    else pass_cnt++;
    rst = 0;
    @(negedge clk);
    ar_phase(32'h1000, 4'd0, 0);
    r_phase({32'd4, 32'd3, 32'd2, 32'd1}, '0, 4'b1000, 4'b0, 4'd0, 0);
    ar_phase(32'h1010, 4'd1, 0);
    r_phase({32'd8, 32'd7, 32'd6, 32'd5}, '0, 4'b1000, 4'b0, 4'd1, 0);
    chk_cnt++; if (done !== 1'b1 || data_sum !== 36 || err_cnt !== 0)
      $display("FAIL mid_rerun: done=%b sum=%0d err=%0d exp 1/36/0", done, data_sum, err_cnt);
    else pass_cnt++;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_ar_stall();
    test_rvalid_toggle();
    test_errors();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
